pipe_addsub: RTL and testbench
==============================

Name: pipe_addsub

Overview:
- Parametrised, pipelined successor to the single-cycle registered adder.
- Adds or subtracts two N-bit operands. The carry chain is split into SEG-bit segments, one pipeline stage per segment, so width scales without lengthening the critical path.
- Valid/ready handshake on input and output; full throughput of one operation per cycle.
- Reports carry-out and signed overflow. Sits in the datapath between operand-register stages and result consumers.

Parameters:
- N, 32, operand/result width in bits; must be an integer multiple of SEG (elaboration error otherwise).
- SEG, 8, segment width in bits. Number of stages S = N/SEG; SEG = N gives a 1-stage adder.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- term_a  input  N  operand A.
- term_b  input  N  operand B.
- sub  input  1  0: A+B; 1: A-B.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result.
- sum  output  N  result.
- carry  output  1  raw carry-out of MSB (for sub: 1 = no borrow).
- overflow  output  1  signed (two's complement) overflow.

Behaviour:
- Reset (async, immediate): all stage valid bits = 0; sum = 0, carry = 0, overflow = 0, out_valid = 0. Any beats in flight are discarded.
- Arithmetic: result = A + (B XOR {N{sub}}) + sub, computed modulo 2^N.
  - carry = bit N of that (N+1)-bit sum.
  - overflow = (A[N-1] == B'[N-1]) && (sum[N-1] != A[N-1]), where B' is the inverted-or-plain B.
- Pipeline structure:
  - Stage k (k = 0..S-1) adds segment k of A and B' plus the carry registered by stage k-1. Stage 0 uses sub as carry-in.
  - Upper operand segments and the sub bit are delayed alongside so they reach their stage in step with their carry.
  - Lower result segments are delayed to de-skew. All N result bits of one beat appear together.
- Latency: exactly S cycles from the accepting edge (in_valid && in_ready) to out_valid for that beat, with no stalls.
- Handshake / stall:
  - Global enable en = !out_valid || out_ready; in_ready = en.
  - When en = 0, every pipeline register, including the output, holds its value. sum, carry and overflow stay stable while out_valid = 1 and out_ready = 0.
  - Bubbles (in_valid = 0 while en = 1) propagate as valid = 0. Data registers may update, but outputs are don't-care while out_valid = 0.
  - Accept and emit in the same cycle is allowed: full rate, no gaps.
- Ordering: results leave in the order operands entered; no reordering and no drops.
- Boundaries:
  - 0xFF..F + 1 wraps to 0 with carry = 1.
  - A - A gives 0 with carry = 1 and overflow = 0.
  - 0 - 1 gives all-ones with carry = 0.
  - Most-negative minus 1 gives overflow = 1.
- in_valid is ignored when in_ready = 0. The source must hold its beat; nothing is latched.

Optional Feature:
- Macro PIPE_ADDSUB_SAT_EN.
- Defined: on overflow, sum is clamped at the output stage.
  - Positive overflow (A[N-1] = 0) gives 0 followed by N-1 ones, i.e. 0x7F..F.
  - Negative overflow gives 1 followed by N-1 zeros, i.e. 0x80..0.
  - overflow and carry are still reported unclamped.
  - Latency is unchanged.
- Undefined: sum wraps modulo 2^N. No clamp logic is synthesised.

Test Plan (N=8, SEG=4, S=2):
- Reset: assert rst mid-simulation with beats in flight -> out_valid=0, sum=0x00, carry=0, overflow=0 immediately; no stale beat emerges after rst deasserts.
- Add wrap: A=0xFF, B=0x01, sub=0, out_ready=1 -> 2 cycles later sum=0x00, carry=1, overflow=0.
- Sub overflow: A=0x80, B=0x01, sub=1 -> sum=0x7F, carry=1, overflow=1. With PIPE_ADDSUB_SAT_EN: sum=0x80, overflow=1.
- Saturate positive: A=0x7F, B=0x01, sub=0 -> sum=0x80, overflow=1. With macro: sum=0x7F.
- Throughput/stall: 8 back-to-back random beats; drop out_ready for 3 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, all 8 results correct and in order, no beat lost or duplicated.
- Borrow: A=0x00, B=0x01, sub=1 -> sum=0xFF, carry=0, overflow=0. SEG=N build (S=1): same vectors with latency 1.

Source files
------------

// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined N-bit adder/subtractor with valid/ready handshake.
// The carry chain is cut into SEG-bit segments with one register stage per segment
// (S = N/SEG stages). Reports raw carry-out and signed overflow.
// Optional feature macro: PIPE_ADDSUB_SAT_EN. When it is defined, the output sum is
// clamped on signed overflow. Without it, the sum wraps modulo 2^N.

module pipe_addsub #(
    parameter int unsigned N   = 32,
    parameter int unsigned SEG = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] term_a,
    input  logic [N-1:0] term_b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         carry,
    output logic         overflow
);

    localparam int unsigned S = N / SEG;

    if (N % SEG != 0) begin : g_bad_cfg
        $error("pipe_addsub: N must be an integer multiple of SEG");
    end

    // Per-stage state. r_a/r_b carry the not-yet-consumed upper operand segments.
    // r_res accumulates the finished low segments, so lower results are de-skewed.
    logic [N-1:0] r_a   [S];
    logic [N-1:0] r_b   [S];
    logic [N-1:0] r_res [S];
    logic         r_cy  [S];
    logic         r_vld [S];
    logic         r_ovf;

    // Stage inputs: stage 0 is fed from the ports, and stage k from register stage k-1.
    logic [N-1:0] w_a_in   [S];
    logic [N-1:0] w_b_in   [S];
    logic [N-1:0] w_res_in [S];
    logic         w_cy_in  [S];
    logic         w_vld_in [S];

    logic [SEG:0] w_seg    [S];
    logic [N-1:0] w_res_nx [S];
    logic         w_ovf_nx;
    logic         w_en;

    // Global stall: everything advances only when the output slot is free or draining.
    assign w_en      = !r_vld[S-1] || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_vld[S-1];
    assign sum       = r_res[S-1];
    assign carry     = r_cy[S-1];
    assign overflow  = r_ovf;

    // Stage input muxing and per-segment addition, including the output-stage flags.
    always_comb begin
        w_a_in[0]   = term_a;
        w_b_in[0]   = term_b ^ {N{sub}};
        w_res_in[0] = '0;
        w_cy_in[0]  = sub;
        w_vld_in[0] = in_valid;
        for (int unsigned k = 1; k < S; k++) begin
            w_a_in[k]   = r_a[k-1];
            w_b_in[k]   = r_b[k-1];
            w_res_in[k] = r_res[k-1];
            w_cy_in[k]  = r_cy[k-1];
            w_vld_in[k] = r_vld[k-1];
        end
        for (int unsigned k = 0; k < S; k++) begin
            w_seg[k] = {1'b0, w_a_in[k][k*SEG +: SEG]}
                     + {1'b0, w_b_in[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, w_cy_in[k]};
            w_res_nx[k] = w_res_in[k];
            w_res_nx[k][k*SEG +: SEG] = w_seg[k][SEG-1:0];
        end
        // Overflow uses the unclamped MSB of the completed result.
        w_ovf_nx = (w_a_in[S-1][N-1] == w_b_in[S-1][N-1])
                && (w_res_nx[S-1][N-1] != w_a_in[S-1][N-1]);
`ifdef PIPE_ADDSUB_SAT_EN
        if (w_ovf_nx) begin
            w_res_nx[S-1] = w_a_in[S-1][N-1] ? {1'b1, {(N-1){1'b0}}}
                                             : {1'b0, {(N-1){1'b1}}};
        end
`endif
    end

    // Pipeline registers: async clear and a common hold whenever the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < S; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_res[k] <= '0;
                r_cy[k]  <= 1'b0;
                r_vld[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_en) begin
            for (int unsigned k = 0; k < S; k++) begin
                r_a[k]   <= w_a_in[k];
                r_b[k]   <= w_b_in[k];
                r_res[k] <= w_res_nx[k];
                r_cy[k]  <= w_seg[k][SEG];
                r_vld[k] <= w_vld_in[k];
            end
            r_ovf <= w_ovf_nx;
        end
    end

endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: directed tests for pipe_addsub at N=8 with SEG=4 (2 stages).
// A second instance with SEG=8 (1 stage) receives the same directed vectors.
// Define PIPE_ADDSUB_SAT_EN to build the saturating variant.

module tb_pipe_addsub;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, sub, out_valid, out_ready, carry, overflow;
    logic [7:0] term_a, term_b, sum;
    logic       v1, rdy1, ov1, c1, o1;
    logic [7:0] sum1;

    int checks = 0;
    int errors = 0;

`ifdef PIPE_ADDSUB_SAT_EN
    localparam logic [7:0] SubOvSum  = 8'h80;
    localparam logic [7:0] SatPosSum = 8'h7F;
`else
    localparam logic [7:0] SubOvSum  = 8'h7F;
    localparam logic [7:0] SatPosSum = 8'h80;
`endif

    always #5 clk = ~clk;

    pipe_addsub #(.N(8), .SEG(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .term_a(term_a), .term_b(term_b), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .carry(carry), .overflow(overflow)
    );

    pipe_addsub #(.N(8), .SEG(8)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
        .term_a(term_a), .term_b(term_b), .sub(sub), .out_valid(ov1),
        .out_ready(out_ready), .sum(sum1), .carry(c1), .overflow(o1)
    );

    // Reference: {overflow, carry, sum} for A + (B ^ {8{sub}}) + sub.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic s);
        logic [7:0] bp;
        logic [8:0] t;
        logic       ov;
        bp = b ^ {8{s}};
        t  = {1'b0, a} + {1'b0, bp} + {8'h00, s};
        ov = (a[7] == bp[7]) && (t[7] != a[7]);
`ifdef PIPE_ADDSUB_SAT_EN
        if (ov) t[7:0] = a[7] ? 8'h80 : 8'h7F;
`endif
        return {ov, t[8], t[7:0]};
    endfunction

    // Send one beat to both instances with out_ready high and collect their results.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          output int lat, output logic [9:0] r,
                          output int lat1, output logic [9:0] r1);
        @(negedge clk);
        term_a = a; term_b = b; sub = s; in_valid = 1'b1; v1 = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; v1 = 1'b0;
        lat1 = ov1 ? 1 : 0;
        r1   = {o1, c1, sum1};
        lat  = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        r = {overflow, carry, sum};
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; v1 = 1'b0; out_ready = 1'b1;
        term_a = '0; term_b = '0; sub = 1'b0;
        #12;
        checks++;
        if ({out_valid, sum, carry, overflow} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b sum=%h c=%b o=%b, want all 0",
                     out_valid, sum, carry, overflow);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if ({ov1, sum1, c1, o1} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs_s1: got valid=%b sum=%h, want 0", ov1, sum1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Common shape of every directed vector: expected {ovf,carry,sum}, latency 2 and 1.
    task automatic test_add_wrap;
        int lat, lat1;
        logic [9:0] r, r1;
        run_op(8'hFF, 8'h01, 1'b0, lat, r, lat1, r1);
        checks++;
        if (r !== {1'b0, 1'b1, 8'h00} || lat != 2) begin
            errors++;
            $display("FAIL add_wrap: got o/c/sum=%b/%b/%h lat=%0d want 0/1/00 lat=2",
                     r[9], r[8], r[7:0], lat);
        end
        checks++;
        if (r1 !== {1'b0, 1'b1, 8'h00} || lat1 != 1) begin
            errors++;
            $display("FAIL add_wrap_s1: got o/c/sum=%b/%b/%h lat=%0d want 0/1/00 lat=1",
                     r1[9], r1[8], r1[7:0], lat1);
        end
    endtask

    task automatic test_sub_overflow;
        int lat, lat1;
        logic [9:0] r, r1;
        run_op(8'h80, 8'h01, 1'b1, lat, r, lat1, r1);
        checks++;
        if (r !== {1'b1, 1'b1, SubOvSum} || lat != 2) begin
            errors++;
            $display("FAIL sub_overflow: got o/c/sum=%b/%b/%h lat=%0d want 1/1/%h lat=2",
                     r[9], r[8], r[7:0], lat, SubOvSum);
        end
        checks++;
        if (r1 !== {1'b1, 1'b1, SubOvSum} || lat1 != 1) begin
            errors++;
            $display("FAIL sub_overflow_s1: got o/c/sum=%b/%b/%h lat=%0d want 1/1/%h lat=1",
                     r1[9], r1[8], r1[7:0], lat1, SubOvSum);
        end
    endtask

    task automatic test_sat_pos;
        int lat, lat1;
        logic [9:0] r, r1;
        run_op(8'h7F, 8'h01, 1'b0, lat, r, lat1, r1);
        checks++;
        if (r !== {1'b1, 1'b0, SatPosSum} || lat != 2) begin
            errors++;
            $display("FAIL sat_pos: got o/c/sum=%b/%b/%h lat=%0d want 1/0/%h lat=2",
                     r[9], r[8], r[7:0], lat, SatPosSum);
        end
        checks++;
        if (r1 !== {1'b1, 1'b0, SatPosSum} || lat1 != 1) begin
            errors++;
            $display("FAIL sat_pos_s1: got o/c/sum=%b/%b/%h lat=%0d want 1/0/%h lat=1",
                     r1[9], r1[8], r1[7:0], lat1, SatPosSum);
        end
    endtask

    task automatic test_borrow;
        int lat, lat1;
        logic [9:0] r, r1;
        run_op(8'h00, 8'h01, 1'b1, lat, r, lat1, r1);
        checks++;
        if (r !== {1'b0, 1'b0, 8'hFF} || lat != 2) begin
            errors++;
            $display("FAIL borrow: got o/c/sum=%b/%b/%h lat=%0d want 0/0/ff lat=2",
                     r[9], r[8], r[7:0], lat);
        end
        checks++;
        if (r1 !== {1'b0, 1'b0, 8'hFF} || lat1 != 1) begin
            errors++;
            $display("FAIL borrow_s1: got o/c/sum=%b/%b/%h lat=%0d want 0/0/ff lat=1",
                     r1[9], r1[8], r1[7:0], lat1);
        end
    endtask

    task automatic test_self_sub;
        int lat, lat1;
        logic [9:0] r, r1;
        run_op(8'h5A, 8'h5A, 1'b1, lat, r, lat1, r1);
        checks++;
        if (r !== {1'b0, 1'b1, 8'h00} || lat != 2) begin
            errors++;
            $display("FAIL self_sub: got o/c/sum=%b/%b/%h lat=%0d want 0/1/00 lat=2",
                     r[9], r[8], r[7:0], lat);
        end
        checks++;
        if (r1 !== {1'b0, 1'b1, 8'h00} || lat1 != 1) begin
            errors++;
            $display("FAIL self_sub_s1: got o/c/sum=%b/%b/%h lat=%0d want 0/1/00 lat=1",
                     r1[9], r1[8], r1[7:0], lat1);
        end
    endtask

    // A carry out of the low segment must reach the high segment: 0x1C + 0x2A = 0x46.
    task automatic test_seg_carry;
        int lat, lat1;
        logic [9:0] r, r1;
        run_op(8'h1C, 8'h2A, 1'b0, lat, r, lat1, r1);
        checks++;
        if (r !== {1'b0, 1'b0, 8'h46} || lat != 2) begin
            errors++;
            $display("FAIL seg_carry: got o/c/sum=%b/%b/%h lat=%0d want 0/0/46 lat=2",
                     r[9], r[8], r[7:0], lat);
        end
        checks++;
        if (r1 !== {1'b0, 1'b0, 8'h46} || lat1 != 1) begin
            errors++;
            $display("FAIL seg_carry_s1: got o/c/sum=%b/%b/%h lat=%0d want 0/0/46 lat=1",
                     r1[9], r1[8], r1[7:0], lat1);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] ea [8];
        logic [7:0] eb [8];
        logic       es [8];
        logic [9:0] exp_r [8];
        logic [9:0] held;
        int sent = 0;
        int rx   = 0;
        int cyc  = 0;
        int dup  = 0;
        for (int i = 0; i < 8; i++) begin
            ea[i] = 8'($urandom_range(0, 255));
            eb[i] = 8'($urandom_range(0, 255));
            es[i] = 1'($urandom_range(0, 1));
            exp_r[i] = model(ea[i], eb[i], es[i]);
        end
        held = '0;
        // Drain the result left over from the directed vectors.
        @(negedge clk);
        in_valid = 1'b0; v1 = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        while (rx < 8 && cyc < 40) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc <= 7);
            if (sent < 8) begin
                in_valid = 1'b1; term_a = ea[sent]; term_b = eb[sent]; sub = es[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_ready: cyc=%0d got in_ready=%b out_valid=%b want 0/1",
                             cyc, in_ready, out_valid);
                end
                if (cyc > 5) begin
                    checks++;
                    if ({overflow, carry, sum} !== held) begin
                        errors++;
                        $display("FAIL stall_hold: cyc=%0d got %h want %h",
                                 cyc, {overflow, carry, sum}, held);
                    end
                end
                held = {overflow, carry, sum};
            end
            if (out_valid && out_ready) begin
                checks++;
                if ({overflow, carry, sum} !== exp_r[rx]) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got o/c/sum=%b/%b/%h want %b/%b/%h", rx,
                             overflow, carry, sum, exp_r[rx][9], exp_r[rx][8], exp_r[rx][7:0]);
                end
                rx++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            cyc++;
        end
        // Nothing further may emerge once all eight have been consumed.
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) begin
            #1;
            if (out_valid) dup++;
            @(negedge clk);
        end
        checks++;
        if (rx != 8 || sent != 8 || dup != 0) begin
            errors++;
            $display("FAIL b2b_count: got sent=%0d received=%0d extra=%0d want 8/8/0",
                     sent, rx, dup);
        end
    endtask

    task automatic test_reset_inflight;
        int stale = 0;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        term_a = 8'h12; term_b = 8'h34; sub = 1'b0;
        @(negedge clk);
        term_a = 8'hFF; term_b = 8'h01;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, sum, carry, overflow} !== 11'b0) begin
            errors++;
            $display("FAIL reset_inflight: got valid=%b sum=%h c=%b o=%b, want all 0",
                     out_valid, sum, carry, overflow);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL reset_no_stale: got %0d stale beats want 0", stale);
        end
    endtask

    initial begin
        test_reset;
        test_add_wrap;
        test_sub_overflow;
        test_sat_pos;
        test_borrow;
        test_self_sub;
        test_seg_carry;
        test_back_to_back;
        test_reset_inflight;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
